// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and constants for native-bus initiators
package mem_bus_pkg;
   typedef enum logic [1:0] {IDLE, REQ, GAP, DRAIN} state_t;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;
   localparam int WORD_BYTES = 4;
   localparam logic [STRB_W-1:0] WSTRB_READ = 4'b0000;
   localparam logic [STRB_W-1:0] KEEP_ALL = 4'hF;
endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: first-word-fall-through FIFO carrying data plus a last flag
module stream_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             wr_last,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_last,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH:0] mem [DEPTH];
   logic [AW:0] wp, rp;
   assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign empty = wp == rp;
   assign {rd_last, rd_data} = mem[rp[AW-1:0]];
   // storage needs no reset; only the pointers define validity
   always_ff @(posedge clk)
      if (wr_en && !full) mem[wp[AW-1:0]] <= {wr_last, wr_data};
   // read/write pointers with wrap bit
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (wr_en && !full) wp <= wp + 1'b1;
         if (rd_en && !empty) rp <= rp + 1'b1;
      end
endmodule

// File: rtl/mem_block_reader.sv
// mem_block_reader: reads a run of bus words and emits them as an AXI-Stream frame
module mem_block_reader
   import mem_bus_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    src_addr,
   input  logic [LEN_WIDTH-1:0] len_words,
   output logic                 busy,
   output logic                 done,
   output logic                 mem_valid,
   input  logic                 mem_ready,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   output logic [STRB_W-1:0]    mem_wstrb,
   input  logic [DATA_W-1:0]    mem_rdata,
   output logic [DATA_W-1:0]    m_axis_tdata,
   output logic [STRB_W-1:0]    m_axis_tkeep,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tlast
);
   state_t state, state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [LEN_WIDTH-1:0] remaining;
   logic fifo_full, fifo_empty, fifo_last, fifo_wr, fifo_rd, last_word, accept;
   assign accept = (state == IDLE) && start;
   assign last_word = remaining == LEN_WIDTH'(1);
   assign fifo_wr = (state == REQ) && mem_ready;
   assign fifo_rd = m_axis_tvalid && m_axis_tready;
   assign busy = state != IDLE;
   assign mem_valid = state == REQ;
   assign mem_addr = addr;
   assign mem_wdata = '0;
   assign mem_wstrb = WSTRB_READ;
   assign m_axis_tkeep = KEEP_ALL;
   assign m_axis_tvalid = !fifo_empty;
   assign m_axis_tlast = !fifo_empty && fifo_last;
   stream_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
      .clk(clk), .rst(rst),
      .wr_en(fifo_wr), .wr_data(mem_rdata), .wr_last(last_word), .full(fifo_full),
      .rd_en(fifo_rd), .rd_data(m_axis_tdata), .rd_last(fifo_last), .empty(fifo_empty)
   );
   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nxt;
   // next state: GAP forces valid low between requests so slaves see a fresh rising edge
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start && len_words != '0) state_nxt = REQ;
         REQ:   if (mem_ready) state_nxt = last_word ? DRAIN : GAP;
         GAP:   if (!fifo_full) state_nxt = REQ;
         DRAIN: if (fifo_rd && m_axis_tlast) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
   // address/count tracking and the completion pulse
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         addr <= '0;
         remaining <= '0;
         done <= 1'b0;
      end else begin
         done <= (accept && len_words == '0) || (state == DRAIN && fifo_rd && m_axis_tlast);
         if (accept) begin
            addr <= src_addr & ~32'h3;
            remaining <= len_words;
         end else if (fifo_wr) begin
            addr <= addr + ADDR_W'(WORD_BYTES);
            remaining <= remaining - 1'b1;
         end
      end
endmodule

// File: tb/tb_mem_block_reader.sv
// tb_mem_block_reader: table-driven checks of the block reader against a small slave model
module tb_mem_block_reader;
   localparam int FD = 4;
   localparam int LW = 16;
   logic clk = 0, rst = 1, start = 0, mem_ready = 0, m_axis_tready = 0;
   logic [31:0] src_addr = 0, mem_rdata = 0;
   logic [LW-1:0] len_words = 0;
   logic busy, done, mem_valid, m_axis_tvalid, m_axis_tlast;
   logic [31:0] mem_addr, mem_wdata, m_axis_tdata;
   logic [3:0] mem_wstrb, m_axis_tkeep;
   int total = 0, bad = 0;
   typedef struct {
      logic [31:0] src;
      int len;
      int stall;
      bit spur;
      bit restart;
      logic [31:0] base;
   } vec_t;
   vec_t vecs[7];

   mem_block_reader #(.FIFO_DEPTH(FD), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .len_words(len_words),
      .busy(busy), .done(done), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int cyc, n_iss, n_beat, n_done, after, iss_stall;
      logic prev_valid, prev_hs, prev_hold, prev_last_hs, prev_tlast, prev_tv_low;
      logic [31:0] prev_tdata;
      {cyc, n_iss, n_beat, n_done, iss_stall} = '0;
      after = -1;
      {prev_valid, prev_hs, prev_hold, prev_last_hs, prev_tlast} = '0;
      prev_tv_low = 1;
      prev_tdata = 0;
      @(negedge clk);
      start = 1;
      src_addr = v.src;
      len_words = LW'(v.len);
      mem_ready = 0;
      m_axis_tready = 0;
      @(negedge clk);
      start = 0;
      while (after < 4 && cyc < 600) begin
         if (cyc == 0) begin
            chk("busy_latency", busy, v.len != 0);
            chk("valid_latency", mem_valid, v.len != 0);
            chk("done_latency", done, v.len == 0);
         end
         if (done) begin
            n_done++;
            chk("done_after_tlast", prev_last_hs, v.len != 0);
            chk("busy_at_done", busy, 0);
            after = 0;
         end
         if (prev_hs) begin
            chk("valid_gap", mem_valid, 0);
            if (prev_tv_low) chk("fwft_visible", m_axis_tvalid, 1);
         end
         if (mem_valid && !prev_valid) begin
            chk("rd_addr", mem_addr, v.base + 32'(4 * n_iss));
            n_iss++;
         end
         mem_ready = (mem_valid && prev_valid) || (!mem_valid && v.spur && cyc % 2 == 1);
         mem_rdata = mem_valid ? pat(mem_addr) : 32'hDEAD_BEEF;
         prev_hs = mem_valid && mem_ready;
         m_axis_tready = cyc >= v.stall;
         if (cyc == v.stall) iss_stall = n_iss;
         if (prev_hold) begin
            chk("tdata_hold", m_axis_tdata, prev_tdata);
            chk("tlast_hold", m_axis_tlast, prev_tlast);
         end
         prev_hold = m_axis_tvalid && !m_axis_tready;
         prev_tdata = m_axis_tdata;
         prev_tlast = m_axis_tlast;
         prev_tv_low = !m_axis_tvalid;
         prev_last_hs = 0;
         if (m_axis_tvalid && m_axis_tready) begin
            chk("tdata", m_axis_tdata, pat(v.base + 32'(4 * n_beat)));
            chk("tlast", m_axis_tlast, n_beat == v.len - 1);
            prev_last_hs = m_axis_tlast;
            n_beat++;
         end
         start = v.restart && cyc == 5;
         if (start) begin
            src_addr = 32'h0009_0000;
            len_words = 2;
         end
         prev_valid = mem_valid;
         @(negedge clk);
         cyc++;
         if (after >= 0) after++;
      end
      if (after < 0) begin
         total++;
         bad++;
         $display("FAIL timeout src=%h len=%0d", v.src, v.len);
      end
      chk("n_reads", n_iss, v.len);
      chk("n_beats", n_beat, v.len);
      chk("n_done", n_done, 1);
      if (v.stall >= 20) chk("reads_before_stall", iss_stall, FD);
      start = 0;
      mem_ready = 0;
      m_axis_tready = 0;
   endtask

   initial begin
      vecs[0] = '{32'h0002_0000, 4, 0, 0, 0, 32'h0002_0000};
      vecs[1] = '{32'h0000_1000, 0, 0, 0, 0, 32'h0000_1000};
      vecs[2] = '{32'h0003_0010, 10, 50, 0, 0, 32'h0003_0010};
      vecs[3] = '{32'hFFFF_FFFA, 3, 0, 0, 0, 32'hFFFF_FFF8};
      vecs[4] = '{32'h0000_0103, 5, 0, 0, 1, 32'h0000_0100};
      vecs[5] = '{32'h0004_0000, 6, 3, 1, 0, 32'h0004_0000};
      vecs[6] = '{32'h0000_0010, 1, 0, 0, 0, 32'h0000_0010};
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", mem_valid, 0);
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_tlast", m_axis_tlast, 0);
      chk("rst_addr", mem_addr, 0);
      chk("wstrb", mem_wstrb, 0);
      chk("wdata", mem_wdata, 0);
      chk("tkeep", m_axis_tkeep, 4'hF);
      rst = 0;
      for (int i = 0; i < 7; i++) run_vec(vecs[i]);
      @(negedge clk);
      start = 1;
      src_addr = 32'h0005_0000;
      len_words = 8;
      mem_ready = 1;
      @(negedge clk);
      start = 0;
      repeat (6) @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      @(posedge clk);
      #2 rst = 1;
      #1;
      chk("async_busy", busy, 0);
      chk("async_valid", mem_valid, 0);
      chk("async_tvalid", m_axis_tvalid, 0);
      chk("async_tlast", m_axis_tlast, 0);
      chk("async_addr", mem_addr, 0);
      chk("async_done", done, 0);
      @(negedge clk);
      mem_ready = 0;
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_done", done, 0);
      end
      run_vec(vecs[0]);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
